// File: rtl/mem_controller_rr.sv
// Round-robin memory controller: NUM_CONSUMERS requesters shared over NUM_CHANNELS memory ports.
// Optional per-channel wait watchdog enabled by defining MEMCTRL_TIMEOUT_EN.
module mem_controller_rr #(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 16,
    parameter int NUM_CONSUMERS  = 4,
    parameter int NUM_CHANNELS   = 2,
    parameter int WRITE_ENABLE   = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                  consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                   mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                   mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_read_data,
    output logic [NUM_CHANNELS-1:0]                   mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                   mem_write_ready,
    output logic [NUM_CHANNELS-1:0]                   timeout_error
);

    // state   | meaning
    // IDLE    | channel free, arbitrates among eligible consumers
    // RD_WAIT | read issued, waiting for mem_read_ready
    // WR_WAIT | write issued, waiting for mem_write_ready
    // RELAY   | consumer ready pulse high, busy released on exit
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RELAY} ch_state_e;

    localparam int  CW    = $clog2(NUM_CONSUMERS);
    localparam bit  WE_ON = (WRITE_ENABLE != 0);

    if (NUM_CONSUMERS < 2 || NUM_CHANNELS < 1 || NUM_CHANNELS > NUM_CONSUMERS ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_controller_rr: invalid parameter set");
    end

    ch_state_e                              state_q [NUM_CHANNELS];
    ch_state_e                              state_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][CW-1:0]        cons_q, cons_d;
    logic [NUM_CONSUMERS-1:0]               busy_q, busy_d;
    logic [CW-1:0]                          rr_ptr_q, rr_ptr_d;
    logic [NUM_CHANNELS-1:0]                mrv_q, mrv_d, mwv_q, mwv_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mra_q, mra_d, mwa_q, mwa_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mwd_q, mwd_d;
    logic [NUM_CONSUMERS-1:0]               crr_q, crr_d, cwr_q, cwr_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] crd_q, crd_d;
    logic [NUM_CONSUMERS-1:0]               claimed;
    logic                                   found;
    int                                     win, c;

`ifdef MEMCTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [NUM_CHANNELS-1:0][TW-1:0] cnt_q, cnt_d;
    logic [NUM_CHANNELS-1:0]         tmo_q, tmo_d;
    assign timeout_error = tmo_q;
`else
    assign timeout_error = '0;
`endif

    always_comb begin
        state_d  = state_q;
        cons_d   = cons_q;
        busy_d   = busy_q;
        rr_ptr_d = rr_ptr_q;
        mrv_d = mrv_q;  mra_d = mra_q;
        mwv_d = mwv_q;  mwa_d = mwa_q;  mwd_d = mwd_q;
        crr_d = crr_q;  cwr_d = cwr_q;  crd_d = crd_q;
        claimed = '0;
        found   = 1'b0;
        win     = 0;
        c       = 0;
`ifdef MEMCTRL_TIMEOUT_EN
        cnt_d = cnt_q;
        tmo_d = tmo_q;
`endif
        // Channels resolve in index order; claimed hides a winner from later channels.
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            case (state_q[i])
                IDLE: begin
                    found = 1'b0;
                    win   = 0;
                    for (int k = 0; k < NUM_CONSUMERS; k++) begin
                        c = int'(rr_ptr_q) + k;
                        if (c >= NUM_CONSUMERS) c = c - NUM_CONSUMERS;
                        if (!found && !busy_q[c] && !claimed[c] &&
                            (consumer_read_valid[c] || (WE_ON && consumer_write_valid[c]))) begin
                            found = 1'b1;
                            win   = c;
                        end
                    end
                    if (found) begin
                        claimed[win] = 1'b1;
                        busy_d[win]  = 1'b1;
                        cons_d[i]    = CW'(win);
                        rr_ptr_d     = (win == NUM_CONSUMERS - 1) ? '0 : CW'(win + 1);
`ifdef MEMCTRL_TIMEOUT_EN
                        cnt_d[i]     = TW'(TIMEOUT_CYCLES - 1);
`endif
                        if (consumer_read_valid[win]) begin
                            state_d[i] = RD_WAIT;
                            mrv_d[i]   = 1'b1;
                            mra_d[i]   = consumer_read_address[win];
                        end else begin
                            state_d[i] = WR_WAIT;
                            mwv_d[i]   = 1'b1;
                            mwa_d[i]   = consumer_write_address[win];
                            mwd_d[i]   = consumer_write_data[win];
                        end
                    end
                end
                RD_WAIT: begin
                    if (mem_read_ready[i]) begin
                        mrv_d[i]            = 1'b0;
                        crr_d[cons_q[i]]    = 1'b1;
                        crd_d[cons_q[i]]    = mem_read_data[i];
                        state_d[i]          = RELAY;
                    end
`ifdef MEMCTRL_TIMEOUT_EN
                    else if (cnt_q[i] == '0) begin
                        mrv_d[i]            = 1'b0;
                        crr_d[cons_q[i]]    = 1'b1;
                        crd_d[cons_q[i]]    = '1;
                        tmo_d[i]            = 1'b1;
                        state_d[i]          = RELAY;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end
`endif
                end
                WR_WAIT: begin
                    if (mem_write_ready[i]) begin
                        mwv_d[i]         = 1'b0;
                        cwr_d[cons_q[i]] = 1'b1;
                        state_d[i]       = RELAY;
                    end
`ifdef MEMCTRL_TIMEOUT_EN
                    else if (cnt_q[i] == '0) begin
                        mwv_d[i]         = 1'b0;
                        cwr_d[cons_q[i]] = 1'b1;
                        tmo_d[i]         = 1'b1;
                        state_d[i]       = RELAY;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end
`endif
                end
                RELAY: begin
                    crr_d[cons_q[i]]  = 1'b0;
                    cwr_d[cons_q[i]]  = 1'b0;
                    busy_d[cons_q[i]] = 1'b0;
                    state_d[i]        = IDLE;
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) state_q[i] <= IDLE;
            cons_q   <= '0;
            busy_q   <= '0;
            rr_ptr_q <= '0;
            mrv_q <= '0;  mra_q <= '0;
            mwv_q <= '0;  mwa_q <= '0;  mwd_q <= '0;
            crr_q <= '0;  cwr_q <= '0;  crd_q <= '0;
`ifdef MEMCTRL_TIMEOUT_EN
            cnt_q <= '0;
            tmo_q <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) state_q[i] <= state_d[i];
            cons_q   <= cons_d;
            busy_q   <= busy_d;
            rr_ptr_q <= rr_ptr_d;
            mrv_q <= mrv_d;  mra_q <= mra_d;
            mwv_q <= mwv_d;  mwa_q <= mwa_d;  mwd_q <= mwd_d;
            crr_q <= crr_d;  cwr_q <= cwr_d;  crd_q <= crd_d;
`ifdef MEMCTRL_TIMEOUT_EN
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
`endif
        end
    end

    assign mem_read_valid       = mrv_q;
    assign mem_read_address     = mra_q;
    assign mem_write_valid      = mwv_q;
    assign mem_write_address    = mwa_q;
    assign mem_write_data       = mwd_q;
    assign consumer_read_ready  = crr_q;
    assign consumer_read_data   = crd_q;
    assign consumer_write_ready = cwr_q;

endmodule
